alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 32-bit MIPS-style integer ALU for the datapath execute stage.
- Decodes the raw 32-bit instruction word, operates on two register operands, and registers:
  - the result `c`
  - a 3-bit flag vector `zon`
  - the HI/LO multiply/divide registers
- One clock, asynchronous active-low reset.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk       input   1   rising-edge clock
- rst_n     input   1   asynchronous active-low reset
- gr1       input   32  first operand (rs value). Also the data operand for all shifts.
- gr2       input   32  second operand (rt value)
- i_datain  input   32  instruction word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0]
- c         output  32  registered result
- zon       output  3   registered flags: zon[2]=zero, zon[1]=overflow, zon[0]=negative
- hi        output  32  HI register
- lo        output  32  LO register

Behaviour:
- Reset and latency:
  - rst_n low asynchronously clears c, zon, hi and lo to 0. Outputs stay 0 until the first rising edge after rst_n goes high.
  - Inputs are sampled and all outputs update on each rising clk edge: one-cycle latency, no handshake, a new operation every cycle.
- Flags:
  - zero = (next c == 0).
  - negative = next c[31].
  - overflow = signed two's-complement overflow for add, sub and addi only; 0 for every other operation.
- R-type (op=000000), selected by funct:
  - 20 add: c = gr1+gr2, overflow detected. 21 addu: same sum, overflow 0.
  - 22 sub: c = gr1-gr2, overflow detected. 23 subu: same difference, overflow 0.
  - 24 and, 25 or, 26 xor, 27 nor: bitwise on gr1, gr2.
  - 2A slt: c = signed(gr1)<signed(gr2) ? 1 : 0.
  - 2B sltu: c = unsigned compare of gr1, gr2, result 1 or 0.
  - Immediate-amount shifts, data gr1, amount shamt:
    - 00 sll: c = gr1<<shamt.
    - 02 srl: logical right shift.
    - 03 sra: arithmetic right shift.
  - 04 sllv, 06 srlv, 07 srav: as sll/srl/sra, amount gr2[4:0].
  - 18 mult: {hi,lo} = signed gr1*gr2. 19 multu: unsigned product.
  - 1A div: lo = quotient, hi = remainder, signed, truncating toward zero; remainder takes the dividend's sign. 1B divu: unsigned.
    - Divide by zero (gr2==0): lo = 32'hFFFFFFFF, hi = gr1.
  - For mult/multu/div/divu: c = 0 and zon reflects c=0 (100).
  - hi/lo change only on mult/multu/div/divu and otherwise hold their value.
- I-type, by op. simm = sign-extended imm; zimm = zero-extended imm:
  - 08 addi: gr1+simm, overflow detected. 09 addiu: gr1+simm, overflow 0.
  - 0C andi, 0D ori, 0E xori: gr1 op zimm.
  - 0A slti: signed compare gr1 < simm. 0B sltiu: unsigned compare gr1 < simm.
  - 0F lui: c = {imm,16'h0}.
  - 04 beq, 05 bne: c = gr1-gr2. The zero flag gives equality; overflow 0.
  - 23 lw, 2B sw: c = gr1+simm (address), overflow 0.
- Illegal or unsupported op/funct:
  - c = 0 and zon = 000 (zero flag forced low so illegal is distinguishable).
  - hi and lo hold.
- Shift amounts are 0..31; a shift by 0 passes gr1 through.
- Mid-operation reset: an asynchronous assert clears everything immediately. No partial state survives.

Test Plan:
- Reset: rst_n=0 with any inputs -> c=0, zon=000, hi=lo=0 immediately; all hold until the first edge after release.
- sll shamt 1 and 2 (and a shift-by-0 check), `i_datain` 00011040 then 00011080 (rt=1, rd=2, funct=00, shamt 1 then 2), `gr1` DDDDDDDD, one edge each:
  - shamt 1: c=BBBBBBBA, zon=001.
  - shamt 2: c=77777774, zon=000.
  - shamt 0: c=gr1.
- sll shamt 1 and 4 of 40404040, `i_datain` 00011040 then 00011100:
  - shamt 1: c=80808080, zon=001.
  - shamt 4: c=04040400, zon=000.
- add overflow, gr1=7FFFFFFF, gr2=00000001:
  - add -> c=80000000, zon=011.
  - addu -> zon=001.
  - sub of equal operands -> c=0, zon=100.
- mult/div, gr1=FFFFFFFE (-2), gr2=00000003:
  - mult -> hi=FFFFFFFF, lo=FFFFFFFA.
  - multu -> unsigned product.
  - div 7/-2 -> lo=FFFFFFFD, hi=00000001.
  - divu by 0 -> lo=FFFFFFFF, hi=gr1.
  - A following `and` leaves hi/lo unchanged.
- I-type, gr1=00000005, gr2=00000005:
  - addi imm=FFFF -> c=00000004.
  - ori imm=8000 -> c=00008005.
  - lui imm=1234 -> c=12340000.
  - slti imm=FFFF -> c=0.
  - beq with equal gr1/gr2 -> zon=100.
  - Illegal op 3F -> c=0, zon=000.

Source files
------------

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered 32-bit MIPS-style integer ALU (execute stage)
//
// Decodes the raw instruction word, operates on the two register operands and
// registers the result, a 3-bit flag vector and the HI/LO multiply/divide
// registers. One-cycle latency: inputs are sampled on every rising clk edge
// and all outputs update on that same edge. There is no handshake; a new
// operation may be issued every cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (clears c, zon, hi, lo)
//   gr1       in   [31:0] first operand (rs); data operand of every shift
//   gr2       in   [31:0] second operand (rt)
//   i_datain  in   [31:0] instruction word
//   c         out  [31:0] registered result
//   zon       out  [2:0]  registered flags {zero, overflow, negative}
//   hi        out  [31:0] HI register
//   lo        out  [31:0] LO register
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  input  logic [31:0]      i_datain,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       zon,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] simm;
  logic [31:0] zimm;

  assign op    = i_datain[31:26];
  assign funct = i_datain[5:0];
  assign shamt = i_datain[10:6];
  assign imm   = i_datain[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0000, imm};

  // Register-specifier fields are resolved by the register file, not here.
  logic unused_fields;
  assign unused_fields = ^i_datain[25:11];

  // Shared arithmetic
  logic [31:0] sum_ab;
  logic [31:0] diff_ab;
  logic [31:0] sum_ai;
  logic        ovf_add;
  logic        ovf_sub;
  logic        ovf_addi;

  assign sum_ab  = gr1 + gr2;
  assign diff_ab = gr1 - gr2;
  assign sum_ai  = gr1 + simm;
  // Signed overflow: operands agree in sign (subtract: disagree) but the
  // result sign differs from the first operand.
  assign ovf_add  = (gr1[31] == gr2[31])  && (sum_ab[31]  != gr1[31]);
  assign ovf_sub  = (gr1[31] != gr2[31])  && (diff_ab[31] != gr1[31]);
  assign ovf_addi = (gr1[31] == simm[31]) && (sum_ai[31]  != gr1[31]);

  // Shifter: funct[2] distinguishes the variable forms (04/06/07) from the
  // immediate-amount forms (00/02/03), so one shifter serves both.
  logic [4:0]  sh_amt;
  logic [31:0] sh_ll;
  logic [31:0] sh_rl;
  logic [31:0] sh_ra;

  assign sh_amt = funct[2] ? gr2[4:0] : shamt;
  assign sh_ll  = gr1 << sh_amt;
  assign sh_rl  = gr1 >> sh_amt;
  assign sh_ra  = $unsigned($signed(gr1) >>> sh_amt);

  // Multiplier: the low 64 bits of the product of sign-extended operands
  // equal the signed 64-bit product.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{gr1[31]}}, gr1} * {{32{gr2[31]}}, gr2};
  assign prod_u = {32'h0, gr1} * {32'h0, gr2};

  // Divider: divide magnitudes unsigned, then restore signs. This gives
  // truncation toward zero with the remainder following the dividend, and
  // -2^31 / -1 wraps to -2^31 instead of trapping.
  logic        div_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  assign div_signed = ~funct[0];
  assign neg_a      = div_signed & gr1[31];
  assign neg_b      = div_signed & gr2[31];
  assign dvd_mag    = neg_a ? (32'h0 - gr1) : gr1;
  assign dvs_mag    = neg_b ? (32'h0 - gr2) : gr2;
  assign div_zero   = (gr2 == 32'h0);
  assign dvs_safe   = div_zero ? 32'h1 : dvs_mag;
  assign q_mag      = dvd_mag / dvs_safe;
  assign r_mag      = dvd_mag % dvs_safe;
  assign quo        = (neg_a ^ neg_b) ? (32'h0 - q_mag) : q_mag;
  assign rem        = neg_a ? (32'h0 - r_mag) : r_mag;

  // Next-state computation
  logic [31:0] c_d,   c_q;
  logic [2:0]  zon_d, zon_q;
  logic [31:0] hi_d,  hi_q;
  logic [31:0] lo_d,  lo_q;
  logic        ovf;
  logic        illegal;

  always_comb begin
    c_d     = 32'h0;
    ovf     = 1'b0;
    illegal = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin c_d = sum_ab;  ovf = ovf_add; end
          FN_ADDU: c_d = sum_ab;
          FN_SUB:  begin c_d = diff_ab; ovf = ovf_sub; end
          FN_SUBU: c_d = diff_ab;
          FN_AND:  c_d = gr1 & gr2;
          FN_OR:   c_d = gr1 | gr2;
          FN_XOR:  c_d = gr1 ^ gr2;
          FN_NOR:  c_d = ~(gr1 | gr2);
          FN_SLT:  c_d = {31'h0, ($signed(gr1) < $signed(gr2))};
          FN_SLTU: c_d = {31'h0, (gr1 < gr2)};
          FN_SLL, FN_SLLV: c_d = sh_ll;
          FN_SRL, FN_SRLV: c_d = sh_rl;
          FN_SRA, FN_SRAV: c_d = sh_ra;
          FN_MULT:  begin hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
          FN_MULTU: begin hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
          FN_DIV, FN_DIVU: begin
            if (div_zero) begin
              hi_d = gr1;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin c_d = sum_ai; ovf = ovf_addi; end
      OP_ADDIU: c_d = sum_ai;
      OP_ANDI:  c_d = gr1 & zimm;
      OP_ORI:   c_d = gr1 | zimm;
      OP_XORI:  c_d = gr1 ^ zimm;
      OP_SLTI:  c_d = {31'h0, ($signed(gr1) < $signed(simm))};
      OP_SLTIU: c_d = {31'h0, (gr1 < simm)};
      OP_LUI:   c_d = {imm, 16'h0000};
      OP_BEQ, OP_BNE: c_d = diff_ab;
      OP_LW, OP_SW:   c_d = sum_ai;
      default: illegal = 1'b1;
    endcase
    // Illegal forces the zero flag low so it is distinguishable from c==0.
    zon_d = illegal ? 3'b000 : {(c_d == 32'h0), ovf, c_d[31]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= 32'h0;
      zon_q <= 3'b000;
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
    end else begin
      c_q   <= c_d;
      zon_q <= zon_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign c   = c_q;
  assign zon = zon_q;
  assign hi  = hi_q;
  assign lo  = lo_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed self-checking bench for alu.
// Inputs are driven on the falling edge, captured on the rising edge, and
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic [31:0] i_datain;
  logic [31:0] c;
  logic [2:0]  zon;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gr1      (gr1),
    .gr2      (gr2),
    .i_datain (i_datain),
    .c        (c),
    .zon      (zon),
    .hi       (hi),
    .lo       (lo)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction builders
  function automatic logic [31:0] r_op(input logic [5:0] funct, input logic [4:0] sa);
    return {6'h00, 5'd1, 5'd2, 5'd3, sa, funct};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cz(input string tag, input logic [31:0] exp_c, input logic [2:0] exp_z);
    chk({tag, ".c"}, c, exp_c);
    chk({tag, ".zon"}, {29'h0, zon}, {29'h0, exp_z});
  endtask

  task automatic chk_hl(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    chk({tag, ".hi"}, hi, exp_hi);
    chk({tag, ".lo"}, lo, exp_lo);
  endtask

  // Driver: one operation per clock
  task automatic step(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_datain = instr;
    gr1      = a;
    gr2      = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with non-trivial inputs present
    rst_n    = 1'b0;
    i_datain = r_op(6'h20, 5'd0);
    gr1      = 32'h1234_5678;
    gr2      = 32'h1111_1111;
    #3;
    chk_cz("reset_async", 32'h0, 3'b000);
    chk_hl("reset_async", 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_cz("reset_held", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cz("reset_release", 32'h0, 3'b000);
    chk_hl("reset_release", 32'h0, 32'h0);

    // Shifts
    step(32'h0001_1040, 32'hDDDD_DDDD, 32'h0);  chk_cz("sll1",  32'hBBBB_BBBA, 3'b001);
    step(32'h0001_1080, 32'hDDDD_DDDD, 32'h0);  chk_cz("sll2",  32'h7777_7774, 3'b000);
    step(32'h0001_1000, 32'hDDDD_DDDD, 32'h0);  chk_cz("sll0",  32'hDDDD_DDDD, 3'b001);
    step(32'h0001_1040, 32'h4040_4040, 32'h0);  chk_cz("sll1b", 32'h8080_8080, 3'b001);
    step(32'h0001_1100, 32'h4040_4040, 32'h0);  chk_cz("sll4b", 32'h0404_0400, 3'b000);
    step(r_op(6'h02, 5'd4), 32'h8000_0000, 32'h0);  chk_cz("srl4", 32'h0800_0000, 3'b000);
    step(r_op(6'h03, 5'd4), 32'h8000_0000, 32'h0);  chk_cz("sra4", 32'hF800_0000, 3'b001);
    step(r_op(6'h04, 5'd0), 32'h0000_0001, 32'h0000_003F);  chk_cz("sllv31", 32'h8000_0000, 3'b001);
    step(r_op(6'h07, 5'd0), 32'h8000_0000, 32'h0000_0024);  chk_cz("srav4",  32'hF800_0000, 3'b001);
    step(r_op(6'h06, 5'd7), 32'h1234_5678, 32'h0000_0000);  chk_cz("srlv0",  32'h1234_5678, 3'b000);

    // Add / sub
    step(r_op(6'h20, 5'd0), 32'h7FFF_FFFF, 32'h0000_0001);  chk_cz("add_ovf",  32'h8000_0000, 3'b011);
    step(r_op(6'h21, 5'd0), 32'h7FFF_FFFF, 32'h0000_0001);  chk_cz("addu",     32'h8000_0000, 3'b001);
    step(r_op(6'h22, 5'd0), 32'h0000_0005, 32'h0000_0005);  chk_cz("sub_eq",   32'h0,         3'b100);
    step(r_op(6'h22, 5'd0), 32'h8000_0000, 32'h0000_0001);  chk_cz("sub_ovf",  32'h7FFF_FFFF, 3'b010);
    step(r_op(6'h23, 5'd0), 32'h8000_0000, 32'h0000_0001);  chk_cz("subu",     32'h7FFF_FFFF, 3'b000);

    // Logic and compares
    step(r_op(6'h24, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);  chk_cz("and",  32'hF000_F000, 3'b001);
    step(r_op(6'h25, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);  chk_cz("or",   32'hFFF0_FFF0, 3'b001);
    step(r_op(6'h26, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);  chk_cz("xor",  32'h0FF0_0FF0, 3'b000);
    step(r_op(6'h27, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);  chk_cz("nor",  32'h000F_000F, 3'b000);
    step(r_op(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001);  chk_cz("slt",  32'h1,         3'b000);
    step(r_op(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001);  chk_cz("sltu", 32'h0,         3'b100);

    // Multiply / divide
    step(r_op(6'h18, 5'd0), 32'hFFFF_FFFE, 32'h0000_0003);
    chk_cz("mult", 32'h0, 3'b100);          chk_hl("mult",  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    step(r_op(6'h19, 5'd0), 32'hFFFF_FFFE, 32'h0000_0003);
    chk_hl("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    step(r_op(6'h1A, 5'd0), 32'h0000_0007, 32'hFFFF_FFFE);
    chk_cz("div", 32'h0, 3'b100);           chk_hl("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD);
    step(r_op(6'h1A, 5'd0), 32'hFFFF_FFF9, 32'h0000_0002);
    chk_hl("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step(r_op(6'h1B, 5'd0), 32'h1234_5678, 32'h0000_0000);
    chk_hl("divu_by0", 32'h1234_5678, 32'hFFFF_FFFF);
    step(r_op(6'h1B, 5'd0), 32'h0000_0064, 32'h0000_0007);
    chk_hl("divu_100_7", 32'h0000_0002, 32'h0000_000E);
    step(r_op(6'h24, 5'd0), 32'h0000_0005, 32'h0000_0005);
    chk_cz("and_after", 32'h5, 3'b000);     chk_hl("and_hold", 32'h0000_0002, 32'h0000_000E);
    step(r_op(6'h1A, 5'd0), 32'h8000_0000, 32'hFFFF_FFFF);
    chk_hl("div_min_m1", 32'h0000_0000, 32'h8000_0000);

    // I-type
    step(i_op(6'h08, 16'hFFFF), 32'h0000_0005, 32'h0000_0005);  chk_cz("addi",      32'h0000_0004, 3'b000);
    step(i_op(6'h08, 16'h0001), 32'h7FFF_FFFF, 32'h0000_0005);  chk_cz("addi_ovf",  32'h8000_0000, 3'b011);
    step(i_op(6'h09, 16'h0001), 32'h7FFF_FFFF, 32'h0000_0005);  chk_cz("addiu",     32'h8000_0000, 3'b001);
    step(i_op(6'h0D, 16'h8000), 32'h0000_0005, 32'h0000_0005);  chk_cz("ori",       32'h0000_8005, 3'b000);
    step(i_op(6'h0C, 16'hFFFF), 32'hFFFF_1234, 32'h0000_0005);  chk_cz("andi",      32'h0000_1234, 3'b000);
    step(i_op(6'h0E, 16'h00FF), 32'h0000_0005, 32'h0000_0005);  chk_cz("xori",      32'h0000_00FA, 3'b000);
    step(i_op(6'h0F, 16'h1234), 32'h0000_0005, 32'h0000_0005);  chk_cz("lui",       32'h1234_0000, 3'b000);
    step(i_op(6'h0A, 16'hFFFF), 32'h0000_0005, 32'h0000_0005);  chk_cz("slti",      32'h0,         3'b100);
    step(i_op(6'h0B, 16'hFFFF), 32'h0000_0005, 32'h0000_0005);  chk_cz("sltiu",     32'h1,         3'b000);
    step(i_op(6'h04, 16'h0010), 32'h0000_0005, 32'h0000_0005);  chk_cz("beq_eq",    32'h0,         3'b100);
    step(i_op(6'h05, 16'h0010), 32'h0000_0005, 32'h0000_0003);  chk_cz("bne_ne",    32'h2,         3'b000);
    step(i_op(6'h23, 16'hFFFC), 32'h0000_1000, 32'h0000_0005);  chk_cz("lw",        32'h0000_0FFC, 3'b000);
    step(i_op(6'h2B, 16'h0010), 32'h0000_1000, 32'h0000_0005);  chk_cz("sw",        32'h0000_1010, 3'b000);

    // Illegal encodings: result 0, zero flag low, hi/lo held
    step(i_op(6'h3F, 16'h0000), 32'h0000_0005, 32'h0000_0005);
    chk_cz("illegal_op", 32'h0, 3'b000);    chk_hl("illegal_op", 32'h0000_0000, 32'h8000_0000);
    step(r_op(6'h3F, 5'd0), 32'h0000_0005, 32'h0000_0005);
    chk_cz("illegal_fn", 32'h0, 3'b000);

    // Asynchronous reset in the middle of a cycle clears everything at once
    step(r_op(6'h18, 5'd0), 32'h0001_0000, 32'h0001_0000);
    chk_hl("mult_big", 32'h0000_0001, 32'h0000_0000);
    step(i_op(6'h0D, 16'h00AA), 32'h0000_0000, 32'h0000_0000);
    chk_cz("ori_pre_rst", 32'h0000_00AA, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cz("mid_reset", 32'h0, 3'b000);
    chk_hl("mid_reset", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(r_op(6'h21, 5'd0), 32'h0000_0002, 32'h0000_0003);
    chk_cz("post_reset_addu", 32'h5, 3'b000);
    chk_hl("post_reset_hold", 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
